filter_luma_ctrl: RTL and testbench

- Sequencing/configuration controller wrapped around the luma lowpass biquad; sits between the luma source and the composite encoder's luma path.
- Owns filter state clearing, coefficient-bank selection (PAL/NTSC) applied only at frame boundaries, blanking substitution and priming.
- Also aligns a bypass path to the filter latency so the output can switch filtered/raw without a timing step.

---
 rtl/filter_ctrl_pkg.sv | 26 ++
 rtl/sync_delay_line.sv | 33 +++
 rtl/filter_luma_ctrl.sv | 148 ++++++++++++++
 tb/tb_filter_luma_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/filter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : filter_ctrl_pkg
// Purpose : Shared types for the luma filter sequencing controller.
// Revision: 1.0 - initial release
// ============================================================================
package filter_ctrl_pkg;

  // Controller phases: clear filter state, feed blank to settle, then run.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Coefficient bank / video standard encoding.
  typedef enum logic [0:0] {
    STD_PAL  = 1'b0,
    STD_NTSC = 1'b1
  } std_t;

  // Width of the priming counter (PRIME_CYCLES up to 255).
  localparam int c_PRIME_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/sync_delay_line.sv
`default_nettype none
// ============================================================================
// Module  : sync_delay_line
// Purpose : Fixed-depth shift-register delay with a loadable reset value.
// Revision: 1.0 - initial release
// ============================================================================
module sync_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift one stage per clock; reset flushes every stage to rst_val.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= rst_val;
    end else begin
      r_stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign dout = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/filter_luma_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : filter_luma_ctrl
// Purpose : Sequencer around the luma lowpass biquad: clears and primes the
//           filter, switches PAL/NTSC coefficients on frame boundaries,
//           blanks outside active video and keeps a latency-matched bypass.
// Revision: 1.0 - initial release
// ============================================================================
module filter_luma_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int         FILTER_LATENCY = 3,
  parameter int         PRIME_CYCLES   = 16,
  parameter logic [7:0] BLANK_LEVEL    = 8'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       std_req,
  input  logic       filter_en,
  input  logic       newframe,
  input  logic       active,
  input  logic [7:0] luma_in,
  output logic [7:0] filt_in,
  output logic       filt_clear,
  output logic       coeff_sel,
  input  logic [7:0] filt_out,
  output logic [7:0] luma_out,
  output logic       busy
);

  // Bypass/active delay matches filt_in register plus filter pipeline.
  localparam int                       c_DLY_DEPTH  = FILTER_LATENCY + 1;
  localparam logic [c_PRIME_CNT_W-1:0] c_PRIME_LAST = c_PRIME_CNT_W'(PRIME_CYCLES - 1);
  localparam logic [3:0]               c_WARM_LAST  = 4'(FILTER_LATENCY + 1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [c_PRIME_CNT_W-1:0] r_prime_cnt;
  logic [c_PRIME_CNT_W-1:0] w_prime_cnt_nxt;
  std_t                     r_std_req;
  std_t                     r_coeff_sel;
  logic                     r_pending;
  logic [3:0]               r_warm_cnt;
  logic [7:0]               r_filt_in;
  logic [7:0]               r_luma_out;
  logic [7:0]               w_dly_luma;
  logic                     w_dly_active;
  logic                     w_warmup;

  // Request register runs through reset so the first CLEAR sees the live request.
  always_ff @(posedge clk) begin
    r_std_req <= std_t'(std_req);
  end

  // FSM state and priming counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= CLEAR;
      r_prime_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_prime_cnt <= w_prime_cnt_nxt;
    end
  end

  // Next-state logic plus state-decoded strobes.
  always_comb begin
    w_state_nxt     = r_state;
    w_prime_cnt_nxt = r_prime_cnt;
    filt_clear      = 1'b0;
    busy            = 1'b1;
    case (r_state)
      CLEAR: begin
        filt_clear      = 1'b1;
        w_state_nxt     = PRIME;
        w_prime_cnt_nxt = '0;
      end
      PRIME: begin
        w_prime_cnt_nxt = r_prime_cnt + 1'b1;
        if (r_prime_cnt == c_PRIME_LAST) w_state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b0;
        if (newframe && r_pending) w_state_nxt = CLEAR;
      end
      default: w_state_nxt = CLEAR;
    endcase
  end

  // Bank loads only while clearing; pending tracks the live mismatch each cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_coeff_sel <= STD_PAL;
      r_pending   <= 1'b0;
    end else if (r_state == CLEAR) begin
      r_coeff_sel <= r_std_req;
      r_pending   <= 1'b0;
    end else begin
      r_pending   <= (r_std_req != r_coeff_sel);
    end
  end

  // Filter input: live samples only in active video while running.
  always_ff @(posedge clk) begin
    if (!rst_n)                        r_filt_in <= BLANK_LEVEL;
    else if (r_state == RUN && active) r_filt_in <= luma_in;
    else                               r_filt_in <= BLANK_LEVEL;
  end

  // Counts RUN cycles until the first post-prime sample reaches filt_out.
  always_ff @(posedge clk) begin
    if (!rst_n)                       r_warm_cnt <= '0;
    else if (r_state != RUN)          r_warm_cnt <= '0;
    else if (r_warm_cnt != c_WARM_LAST) r_warm_cnt <= r_warm_cnt + 4'd1;
  end

  assign w_warmup = (r_state == PRIME) || ((r_state == RUN) && (r_warm_cnt != c_WARM_LAST));

  sync_delay_line #(.WIDTH(8), .DEPTH(c_DLY_DEPTH)) u_dly_luma (
    .clk     (clk),
    .rst_n   (rst_n),
    .rst_val (BLANK_LEVEL),
    .din     (luma_in),
    .dout    (w_dly_luma)
  );

  sync_delay_line #(.WIDTH(1), .DEPTH(c_DLY_DEPTH)) u_dly_active (
    .clk     (clk),
    .rst_n   (rst_n),
    .rst_val (1'b0),
    .din     (active),
    .dout    (w_dly_active)
  );

  // Output select: blank outside active, bypass while warming or disabled.
  always_ff @(posedge clk) begin
    if (!rst_n)                      r_luma_out <= BLANK_LEVEL;
    else if (!w_dly_active)          r_luma_out <= BLANK_LEVEL;
    else if (w_warmup || !filter_en) r_luma_out <= w_dly_luma;
    else                             r_luma_out <= filt_out;
  end

  assign filt_in   = r_filt_in;
  assign luma_out  = r_luma_out;
  assign coeff_sel = r_coeff_sel;

endmodule
`default_nettype wire

// File: tb/tb_filter_luma_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_filter_luma_ctrl
// Purpose : Directed, table-driven bench for filter_luma_ctrl with a filter
//           stub that echoes filt_in after FILTER_LATENCY cycles, tagged +1 so
//           filtered and bypass samples can be told apart.
// Revision: 1.0 - initial release
// ============================================================================
module tb_filter_luma_ctrl;

  localparam int         c_LAT   = 3;
  localparam int         c_PRIME = 16;
  localparam logic [7:0] c_BLANK = 8'd64;

  logic       clk = 1'b0;
  logic       rst_n, std_req, filter_en, newframe, active;
  logic [7:0] luma_in, filt_in, filt_out, luma_out;
  logic       filt_clear, coeff_sel, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  filter_luma_ctrl #(
    .FILTER_LATENCY (c_LAT),
    .PRIME_CYCLES   (c_PRIME),
    .BLANK_LEVEL    (c_BLANK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .std_req    (std_req),
    .filter_en  (filter_en),
    .newframe   (newframe),
    .active     (active),
    .luma_in    (luma_in),
    .filt_in    (filt_in),
    .filt_clear (filt_clear),
    .coeff_sel  (coeff_sel),
    .filt_out   (filt_out),
    .luma_out   (luma_out),
    .busy       (busy)
  );

  // Filter stub: three-stage echo of filt_in, output tagged +1.
  logic [7:0] s0 = 8'd0, s1 = 8'd0, s2 = 8'd0;
  always @(posedge clk) begin
    s0 <= filt_in;
    s1 <= s0;
    s2 <= s1;
  end
  assign filt_out = s2 + 8'd1;

  typedef struct {
    int         n;
    logic       rst_n, std, fen, nf, act;
    logic [7:0] luma;
    logic       e_clr, e_busy, e_coeff;
    logic [7:0] e_lo;
    logic       chk_lo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int n, logic r, logic s, logic f, logic nf, logic a,
                              logic [7:0] l, logic ec, logic eb, logic eco,
                              logic [7:0] elo, logic clo);
    vec_t v;
    v.n = n; v.rst_n = r; v.std = s; v.fen = f; v.nf = nf; v.act = a; v.luma = l;
    v.e_clr = ec; v.e_busy = eb; v.e_coeff = eco; v.e_lo = elo; v.chk_lo = clo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act_v, input logic [7:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act_v, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; std_req = 1'b0; filter_en = 1'b0; newframe = 1'b0;
    active = 1'b0; luma_in = 8'd0;

    //                n  rst std fen nf act luma  clr busy coef lo  chk
    // reset, release and priming
    tbl.push_back(mk( 3, 0, 0, 0, 0, 0,   0,  1, 1, 0,  64, 1));
    tbl.push_back(mk( 1, 1, 0, 0, 0, 0,   0,  0, 1, 0,  64, 1));
    tbl.push_back(mk(15, 1, 0, 0, 0, 0,   0,  0, 1, 0,  64, 1));
    tbl.push_back(mk( 1, 1, 0, 0, 0, 0,   0,  0, 0, 0,  64, 1));
    // bypass step 64 -> 200, five-cycle latency
    tbl.push_back(mk( 8, 1, 0, 0, 0, 1,  64,  0, 0, 0,  64, 1));
    tbl.push_back(mk( 4, 1, 0, 0, 0, 1, 200,  0, 0, 0,  64, 1));
    tbl.push_back(mk( 1, 1, 0, 0, 0, 1, 200,  0, 0, 0, 200, 1));
    // filtered path, filter_en toggles, active gating
    tbl.push_back(mk( 1, 1, 0, 1, 0, 1, 200,  0, 0, 0, 201, 1));
    tbl.push_back(mk( 4, 1, 0, 1, 0, 1, 100,  0, 0, 0, 201, 1));
    tbl.push_back(mk( 1, 1, 0, 1, 0, 1, 100,  0, 0, 0, 101, 1));
    tbl.push_back(mk( 1, 1, 0, 0, 0, 1, 100,  0, 0, 0, 100, 1));
    tbl.push_back(mk( 1, 1, 0, 1, 0, 1, 100,  0, 0, 0, 101, 1));
    tbl.push_back(mk( 4, 1, 0, 1, 0, 0, 100,  0, 0, 0, 101, 1));
    tbl.push_back(mk( 1, 1, 0, 1, 0, 0, 100,  0, 0, 0,  64, 1));
    tbl.push_back(mk( 4, 1, 0, 1, 0, 1, 100,  0, 0, 0,  64, 1));
    tbl.push_back(mk( 1, 1, 0, 1, 0, 1, 100,  0, 0, 0, 101, 1));
    // PAL -> NTSC mid-frame, applied at newframe, then warm-up window
    tbl.push_back(mk( 5, 1, 1, 1, 0, 1, 100,  0, 0, 0, 101, 1));
    tbl.push_back(mk( 1, 1, 1, 1, 1, 1, 100,  1, 1, 0, 101, 1));
    tbl.push_back(mk( 1, 1, 1, 1, 0, 1, 100,  0, 1, 1, 101, 1));
    tbl.push_back(mk(15, 1, 1, 1, 0, 1, 100,  0, 1, 1, 100, 1));
    tbl.push_back(mk( 1, 1, 1, 1, 0, 1, 100,  0, 0, 1, 100, 1));
    tbl.push_back(mk( 4, 1, 1, 1, 0, 1, 100,  0, 0, 1, 100, 1));
    tbl.push_back(mk( 1, 1, 1, 1, 0, 1, 100,  0, 0, 1, 101, 1));
    // request reverted before newframe: no switch
    tbl.push_back(mk( 3, 1, 0, 1, 0, 1, 100,  0, 0, 1, 101, 1));
    tbl.push_back(mk( 3, 1, 1, 1, 0, 1, 100,  0, 0, 1, 101, 1));
    tbl.push_back(mk( 1, 1, 1, 1, 1, 1, 100,  0, 0, 1, 101, 1));
    // switch to PAL, newframe during PRIME ignored, next one in RUN acts
    tbl.push_back(mk( 3, 1, 0, 1, 0, 1, 100,  0, 0, 1, 101, 1));
    tbl.push_back(mk( 1, 1, 0, 1, 1, 1, 100,  1, 1, 1, 101, 1));
    tbl.push_back(mk( 1, 1, 0, 1, 0, 1, 100,  0, 1, 0, 101, 1));
    tbl.push_back(mk( 3, 1, 1, 1, 0, 1, 100,  0, 1, 0, 100, 1));
    tbl.push_back(mk( 1, 1, 1, 1, 1, 1, 100,  0, 1, 0, 100, 1));
    tbl.push_back(mk(11, 1, 1, 1, 0, 1, 100,  0, 1, 0, 100, 1));
    tbl.push_back(mk( 1, 1, 1, 1, 0, 1, 100,  0, 0, 0, 100, 1));
    tbl.push_back(mk( 1, 1, 1, 1, 1, 1, 100,  1, 1, 0, 100, 1));
    tbl.push_back(mk( 1, 1, 1, 1, 0, 1, 100,  0, 1, 1,   0, 0));

    foreach (tbl[i]) begin
      rst_n     = tbl[i].rst_n;
      std_req   = tbl[i].std;
      filter_en = tbl[i].fen;
      newframe  = tbl[i].nf;
      active    = tbl[i].act;
      luma_in   = tbl[i].luma;
      step(tbl[i].n);
      chk($sformatf("row%0d filt_clear", i), {7'd0, filt_clear}, {7'd0, tbl[i].e_clr});
      chk($sformatf("row%0d busy", i),       {7'd0, busy},       {7'd0, tbl[i].e_busy});
      chk($sformatf("row%0d coeff_sel", i),  {7'd0, coeff_sel},  {7'd0, tbl[i].e_coeff});
      if (tbl[i].chk_lo) chk($sformatf("row%0d luma_out", i), luma_out, tbl[i].e_lo);
    end

    // Reset pulse mid-PRIME with NTSC bank loaded.
    newframe = 1'b0;
    step(4);
    rst_n = 1'b0;
    step(1);
    chk("rst coeff_sel",  {7'd0, coeff_sel},  8'd0);
    chk("rst filt_clear", {7'd0, filt_clear}, 8'd1);
    chk("rst busy",       {7'd0, busy},       8'd1);
    chk("rst luma_out",   luma_out,           8'd64);
    chk("rst filt_in",    filt_in,            8'd64);
    rst_n = 1'b1;
    step(1);
    chk("post-rst coeff_sel",  {7'd0, coeff_sel},  8'd1);
    chk("post-rst filt_clear", {7'd0, filt_clear}, 8'd0);
    chk("post-rst luma_out",   luma_out,           8'd64);
    step(3);
    chk("dly flushed luma_out", luma_out, 8'd64);
    step(1);
    chk("dly refill luma_out",  luma_out, 8'd100);
    step(12);
    chk("rerun busy",         {7'd0, busy}, 8'd0);
    chk("rerun filt_in blank", filt_in,     8'd64);
    step(1);
    chk("rerun filt_in live",  filt_in,     8'd100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
